// File: rtl/id_issue_stage_if.sv
// ID/EX pipeline bus. The issue stage drives it as master; the EX stage consumes it as slave
// and returns out_ready.
interface id_issue_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_data_s;
  logic [XLEN-1:0]   out_data_t;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc_jump;
  logic [XLEN-1:0]   out_pc_next;
  logic [5:0]        out_opcode;
  logic [5:0]        out_funct;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;

  modport master (
    output out_valid, out_ctrl, out_data_s, out_data_t, out_imm, out_pc_jump, out_pc_next,
           out_opcode, out_funct, out_rs, out_rt, out_rd,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ctrl, out_data_s, out_data_t, out_imm, out_pc_jump, out_pc_next,
           out_opcode, out_funct, out_rs, out_rt, out_rd,
    output out_ready
  );
endinterface

// File: rtl/id_issue_stage.sv
// MIPS decode/issue stage: register file, operand forwarding mux, immediate/jump-target build
// and a valid/ready ID/EX register with hazard bubbles, flush and saturating perf counters.
module id_issue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NFWD   = 3,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SELW   = $clog2(NFWD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic [XLEN-1:0]    pc_next,
  input  logic [CTRL_W-1:0]  dec_ctrl,
  input  logic               hazard_stall,
  input  logic [SELW-1:0]    fwd_sel_rs,
  input  logic [SELW-1:0]    fwd_sel_rt,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic [4:0]         rs_probe,
  output logic [4:0]         rt_probe,
  output logic [15:0]        instr_top,
  id_issue_stage_if.master   ex_io,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   bubble_count
);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign opcode       = instruction[31:26];
  assign rs           = instruction[25:21];
  assign rt           = instruction[20:16];
  assign rd           = instruction[15:11];
  assign funct        = instruction[5:0];
  assign unused_shamt = ^instruction[10:6];

  assign rs_probe  = rs;
  assign rt_probe  = rt;
  assign instr_top = instruction[31:16];

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_s, rf_t;
  logic [XLEN-1:0] opnd_s, opnd_t;
  logic [XLEN-1:0] imm, pc_jump;

  // Read ports bypass a same-cycle writeback so the operand is never one write stale.
  always_comb begin
    rf_s = '0;
    rf_t = '0;
    if (rs != 5'd0) rf_s = (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
    if (rt != 5'd0) rf_t = (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
  end

  // Out-of-range selects deliberately fall through to the register-file value.
  always_comb begin
    opnd_s = rf_s;
    opnd_t = rf_t;
    for (int unsigned k = 1; k <= NFWD; k++) begin
      if (32'(fwd_sel_rs) == k) opnd_s = fwd_data[(k-1)*XLEN +: XLEN];
      if (32'(fwd_sel_rt) == k) opnd_t = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  always_comb begin
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm = XLEN'(instruction[15:0]);
      6'h0F:               imm = XLEN'($signed({instruction[15:0], 16'h0000}));
      default:             imm = XLEN'($signed(instruction[15:0]));
    endcase
  end

  assign pc_jump = {pc_next[XLEN-1:28], instruction[25:0], 2'b00};

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   data_s_q, data_t_q, imm_q, pc_jump_q, pc_next_q;
  logic [5:0]        opcode_q, funct_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              free, stall_inc, bubble_inc;

  assign free       = !valid_q || ex_io.out_ready;
  assign in_ready   = free && !hazard_stall && !reset;
  assign stall_inc  = in_valid && hazard_stall;
  assign bubble_inc = !flush && free && hazard_stall && in_valid;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_inc && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bubble_inc && bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_s_q     <= '0;
      data_t_q     <= '0;
      imm_q        <= '0;
      pc_jump_q    <= '0;
      pc_next_q    <= '0;
      opcode_q     <= '0;
      funct_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      if (wb_en && wb_addr != 5'd0) rf_q[wb_addr] <= wb_data;

      // Flush beats hold; a stalled-but-free stage turns into a bubble, otherwise load or drain.
      if (flush) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end else if (free) begin
        if (hazard_stall) begin
          valid_q <= 1'b0;
          ctrl_q  <= '0;
        end else if (in_valid) begin
          valid_q   <= 1'b1;
          ctrl_q    <= dec_ctrl;
          data_s_q  <= opnd_s;
          data_t_q  <= opnd_t;
          imm_q     <= imm;
          pc_jump_q <= pc_jump;
          pc_next_q <= pc_next;
          opcode_q  <= opcode;
          funct_q   <= funct;
          rs_q      <= rs;
          rt_q      <= rt;
          rd_q      <= rd;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign ex_io.out_valid   = valid_q;
  assign ex_io.out_ctrl    = ctrl_q;
  assign ex_io.out_data_s  = data_s_q;
  assign ex_io.out_data_t  = data_t_q;
  assign ex_io.out_imm     = imm_q;
  assign ex_io.out_pc_jump = pc_jump_q;
  assign ex_io.out_pc_next = pc_next_q;
  assign ex_io.out_opcode  = opcode_q;
  assign ex_io.out_funct   = funct_q;
  assign ex_io.out_rs      = rs_q;
  assign ex_io.out_rt      = rt_q;
  assign ex_io.out_rd      = rd_q;

  assign stall_count  = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: a default instance and a small one (NFWD=2, CNT_W=2) share stimulus
// and are checked against a cycle-level behavioural model.
module tb_id_issue_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, hazard_stall, wb_en, out_ready;
  logic [31:0] instruction, pc_next, wb_data;
  logic [15:0] dec_ctrl;
  logic [1:0]  sel_rs, sel_rt;
  logic [95:0] fwd_data;
  logic [4:0]  wb_addr;

  logic        in_ready_b, in_ready_s;
  logic [4:0]  rs_probe_b, rt_probe_b, rs_probe_s, rt_probe_s;
  logic [15:0] instr_top_b, instr_top_s;
  logic [15:0] stall_b, bubble_b;
  logic [1:0]  stall_s, bubble_s;

  id_issue_stage_if #(.XLEN(32), .CTRL_W(16)) ex_b ();
  id_issue_stage_if #(.XLEN(32), .CTRL_W(16)) ex_s ();
  assign ex_b.out_ready = out_ready;
  assign ex_s.out_ready = out_ready;

  id_issue_stage #(.XLEN(32), .NFWD(3), .CTRL_W(16), .CNT_W(16)) u_big (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instruction(instruction), .pc_next(pc_next), .dec_ctrl(dec_ctrl),
    .hazard_stall(hazard_stall), .fwd_sel_rs(sel_rs), .fwd_sel_rt(sel_rt),
    .fwd_data(fwd_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_probe(rs_probe_b), .rt_probe(rt_probe_b), .instr_top(instr_top_b), .ex_io(ex_b),
    .stall_count(stall_b), .bubble_count(bubble_b)
  );

  id_issue_stage #(.XLEN(32), .NFWD(2), .CTRL_W(16), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .instruction(instruction), .pc_next(pc_next), .dec_ctrl(dec_ctrl),
    .hazard_stall(hazard_stall), .fwd_sel_rs(sel_rs), .fwd_sel_rt(sel_rt),
    .fwd_data(fwd_data[63:0]), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_probe(rs_probe_s), .rt_probe(rt_probe_s), .instr_top(instr_top_s), .ex_io(ex_s),
    .stall_count(stall_s), .bubble_count(bubble_s)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [15:0] m_ctrl;
  logic [31:0] m_s, m_t, m_s2, m_t2, m_imm, m_jump, m_pcn;
  logic [5:0]  m_op, m_fn;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_stall, m_bubble;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rf_read(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] pick(logic [1:0] sel, logic [4:0] a, int nfwd);
    if (int'(sel) >= 1 && int'(sel) <= nfwd) return fwd_data[(int'(sel) - 1) * 32 +: 32];
    return rf_read(a);
  endfunction

  function automatic logic [31:0] imm_of(logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, ins[15:0]};
    if (op == 6'h0F) return {ins[15:0], 16'h0000};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  task automatic model_edge();
    logic free;
    if (reset) begin
      m_valid = 1'b0; m_ctrl = '0; m_s = '0; m_t = '0; m_s2 = '0; m_t2 = '0;
      m_imm = '0; m_jump = '0; m_pcn = '0; m_op = '0; m_fn = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_stall = 0; m_bubble = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      free = !m_valid || out_ready;
      if (in_valid && hazard_stall) m_stall++;
      if (flush) begin
        m_valid = 1'b0; m_ctrl = '0;
      end else if (free) begin
        if (hazard_stall) begin
          m_valid = 1'b0; m_ctrl = '0;
          if (in_valid) m_bubble++;
        end else if (in_valid) begin
          m_valid = 1'b1;
          m_ctrl  = dec_ctrl;
          m_s     = pick(sel_rs, instruction[25:21], 3);
          m_t     = pick(sel_rt, instruction[20:16], 3);
          m_s2    = pick(sel_rs, instruction[25:21], 2);
          m_t2    = pick(sel_rt, instruction[20:16], 2);
          m_imm   = imm_of(instruction);
          m_jump  = {pc_next[31:28], instruction[25:0], 2'b00};
          m_pcn   = pc_next;
          m_op    = instruction[31:26];
          m_fn    = instruction[5:0];
          m_rs    = instruction[25:21];
          m_rt    = instruction[20:16];
          m_rd    = instruction[15:11];
        end else begin
          m_valid = 1'b0;
        end
      end
      if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; hazard_stall = 1'b0; wb_en = 1'b0;
    out_ready = 1'b1; instruction = '0; pc_next = '0; dec_ctrl = '0;
    sel_rs = '0; sel_rt = '0; fwd_data = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; step();
    reset = 1'b0; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF; step();
    idle(); reset = 1'b1; in_valid = 1'b1; dec_ctrl = 16'hFFFF; #1;
    checks++;
    if (in_ready_b !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready_b);
    end
    step(); step();
    checks++;
    if (ex_b.out_valid !== 1'b0 || ex_b.out_ctrl !== 16'h0) begin
      errors++; $display("FAIL reset_valid_ctrl: got %0b/%h want 0/0000", ex_b.out_valid,
                         ex_b.out_ctrl);
    end
    checks++;
    if ({ex_b.out_data_s, ex_b.out_data_t, ex_b.out_imm, ex_b.out_pc_jump, ex_b.out_rd}
        !== '0) begin
      errors++; $display("FAIL reset_fields: data_s=%h imm=%h not zero", ex_b.out_data_s,
                         ex_b.out_imm);
    end
    checks++;
    if (stall_b !== 16'h0 || bubble_b !== 16'h0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_b, bubble_b);
    end
    idle(); in_valid = 1'b1; instruction = rtype(5'd9, 5'd0, 5'd1, 6'h21); step();
    checks++;
    if (ex_b.out_data_s !== 32'h0) begin
      errors++; $display("FAIL reset_regfile: r9 got %h want 00000000", ex_b.out_data_s);
    end
    idle(); step();
  endtask

  task automatic test_basic();
    idle(); wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678; step();
    idle(); in_valid = 1'b1; instruction = 32'h00A0_1821; dec_ctrl = 16'h5A5A; #1;
    checks++;
    if (in_ready_b !== 1'b1) begin
      errors++; $display("FAIL basic_in_ready: got %0b want 1", in_ready_b);
    end
    checks++;
    if (rs_probe_b !== 5'd5 || rt_probe_b !== 5'd0 || instr_top_b !== 16'h00A0) begin
      errors++; $display("FAIL basic_probes: got %0d/%0d/%h want 5/0/00a0", rs_probe_b,
                         rt_probe_b, instr_top_b);
    end
    step();
    checks++;
    if (ex_b.out_valid !== 1'b1 || ex_b.out_data_s !== 32'h1234_5678 ||
        ex_b.out_data_t !== 32'h0 || ex_b.out_rd !== 5'd3) begin
      errors++; $display("FAIL basic_load: got v=%0b s=%h t=%h rd=%0d want 1/12345678/0/3",
                         ex_b.out_valid, ex_b.out_data_s, ex_b.out_data_t, ex_b.out_rd);
    end
    checks++;
    if (ex_b.out_ctrl !== 16'h5A5A || ex_b.out_funct !== 6'h21 || ex_b.out_opcode !== 6'h0) begin
      errors++; $display("FAIL basic_ctrl: got ctrl=%h funct=%h want 5a5a/21", ex_b.out_ctrl,
                         ex_b.out_funct);
    end
    idle(); step();
    checks++;
    if (ex_b.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: got valid %0b want 0", ex_b.out_valid);
    end
  endtask

  task automatic test_write_through();
    idle(); in_valid = 1'b1; instruction = itype(6'h08, 5'd7, 5'd2, 16'h0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hAAAA_0000; step();
    checks++;
    if (ex_b.out_data_s !== 32'hAAAA_0000) begin
      errors++; $display("FAIL wt_bypass: got %h want aaaa0000", ex_b.out_data_s);
    end
    instruction = rtype(5'd7, 5'd0, 5'd4, 6'h21); wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    step();
    checks++;
    if (ex_b.out_data_t !== 32'h0 || ex_b.out_data_s !== 32'hAAAA_0000) begin
      errors++; $display("FAIL wt_r0: got t=%h s=%h want 0/aaaa0000", ex_b.out_data_t,
                         ex_b.out_data_s);
    end
    idle(); step();
  endtask

  task automatic test_imm();
    logic [5:0]  ops  [5] = '{6'h0D, 6'h08, 6'h0F, 6'h0E, 6'h0C};
    logic [15:0] imms [5] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h8001};
    logic [31:0] exps [5] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'h0000_FFFF,
                              32'h0000_8001};
    for (int i = 0; i < 5; i++) begin
      idle(); in_valid = 1'b1; instruction = itype(ops[i], 5'd1, 5'd2, imms[i]); step();
      checks++;
      if (ex_b.out_imm !== exps[i] || ex_b.out_opcode !== ops[i]) begin
        errors++; $display("FAIL imm_op%h: got %h want %h", ops[i], ex_b.out_imm, exps[i]);
      end
    end
    idle(); in_valid = 1'b1; pc_next = 32'h9000_0004;
    instruction = {6'h02, 26'h012_3457}; step();
    checks++;
    if (ex_b.out_pc_jump !== 32'h9048_D15C || ex_b.out_pc_next !== 32'h9000_0004 ||
        ex_b.out_imm !== 32'h0000_3457) begin
      errors++; $display("FAIL jump_target: got %h/%h/%h want 9048d15c/90000004/00003457",
                         ex_b.out_pc_jump, ex_b.out_pc_next, ex_b.out_imm);
    end
    idle(); step();
  endtask

  task automatic test_forward();
    logic [1:0]  srs [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic [1:0]  srt [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
    logic [31:0] bs  [4] = '{32'hB, 32'hA, 32'hC, 32'h66};
    logic [31:0] bt  [4] = '{32'hC, 32'h66, 32'hB, 32'hA};
    logic [31:0] ss  [4] = '{32'hB, 32'hA, 32'h66, 32'h66};
    logic [31:0] st  [4] = '{32'h66, 32'h66, 32'hB, 32'hA};
    idle(); wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66; step();
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1'b1; instruction = rtype(5'd6, 5'd6, 5'd1, 6'h21);
      fwd_data = {32'hC, 32'hB, 32'hA}; sel_rs = srs[i]; sel_rt = srt[i]; step();
      checks++;
      if (ex_b.out_data_s !== bs[i] || ex_b.out_data_t !== bt[i]) begin
        errors++; $display("FAIL fwd_big%0d: got %h/%h want %h/%h", i, ex_b.out_data_s,
                           ex_b.out_data_t, bs[i], bt[i]);
      end
      checks++;
      if (ex_s.out_data_s !== ss[i] || ex_s.out_data_t !== st[i]) begin
        errors++; $display("FAIL fwd_small%0d: got %h/%h want %h/%h", i, ex_s.out_data_s,
                           ex_s.out_data_t, ss[i], st[i]);
      end
    end
    idle(); step();
  endtask

  task automatic test_hold_and_bubble();
    idle(); reset = 1'b1; step();
    idle(); in_valid = 1'b1; instruction = rtype(5'd3, 5'd4, 5'd10, 6'h20);
    dec_ctrl = 16'h1234; sel_rs = 2'd1; fwd_data = {32'h0, 32'h0, 32'h1111}; step();
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b0; in_valid = 1'b1; instruction = rtype(5'd5, 5'd6, 5'd20, 6'h22);
      dec_ctrl = 16'hBEEF; fwd_data = {$urandom, $urandom, $urandom}; #1;
      checks++;
      if (in_ready_b !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready%0d: got %0b want 0", c, in_ready_b);
      end
      step();
      checks++;
      if (ex_b.out_valid !== 1'b1 || ex_b.out_data_s !== 32'h1111 || ex_b.out_rd !== 5'd10 ||
          ex_b.out_ctrl !== 16'h1234) begin
        errors++; $display("FAIL hold_stable%0d: got v=%0b s=%h rd=%0d ctrl=%h", c,
                           ex_b.out_valid, ex_b.out_data_s, ex_b.out_rd, ex_b.out_ctrl);
      end
    end
    out_ready = 1'b1; hazard_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (ex_b.out_valid !== 1'b0 || ex_b.out_ctrl !== 16'h0) begin
        errors++; $display("FAIL bubble%0d: got v=%0b ctrl=%h want 0/0000", c, ex_b.out_valid,
                           ex_b.out_ctrl);
      end
    end
    checks++;
    if (bubble_b !== 16'd2 || stall_b !== 16'd2) begin
      errors++; $display("FAIL bubble_counts: got bubble=%0d stall=%0d want 2/2", bubble_b,
                         stall_b);
    end
    hazard_stall = 1'b0; step();
    checks++;
    if (ex_b.out_valid !== 1'b1 || ex_b.out_rd !== 5'd20 || ex_b.out_ctrl !== 16'hBEEF) begin
      errors++; $display("FAIL stall_release: got v=%0b rd=%0d ctrl=%h want 1/20/beef",
                         ex_b.out_valid, ex_b.out_rd, ex_b.out_ctrl);
    end
    idle(); step();
  endtask

  task automatic test_flush();
    idle(); in_valid = 1'b1; instruction = rtype(5'd1, 5'd2, 5'd3, 6'h21); dec_ctrl = 16'h00F0;
    step();
    out_ready = 1'b0; flush = 1'b1; instruction = rtype(5'd1, 5'd2, 5'd7, 6'h21); step();
    checks++;
    if (ex_b.out_valid !== 1'b0 || ex_b.out_ctrl !== 16'h0) begin
      errors++; $display("FAIL flush_hold: got v=%0b ctrl=%h want 0/0000", ex_b.out_valid,
                         ex_b.out_ctrl);
    end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready_b !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %0b want 1", in_ready_b);
    end
    step();
    checks++;
    if (ex_b.out_valid !== 1'b0 || ex_b.out_ctrl !== 16'h0) begin
      errors++; $display("FAIL flush_load: got v=%0b ctrl=%h want 0/0000", ex_b.out_valid,
                         ex_b.out_ctrl);
    end
    flush = 1'b0; step();
    checks++;
    if (ex_b.out_valid !== 1'b1 || ex_b.out_rd !== 5'd7) begin
      errors++; $display("FAIL flush_recover: got v=%0b rd=%0d want 1/7", ex_b.out_valid,
                         ex_b.out_rd);
    end
    idle(); step();
  endtask

  task automatic test_saturate_and_reset();
    idle(); reset = 1'b1; step();
    idle(); in_valid = 1'b1; hazard_stall = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (stall_s !== 2'd3 || bubble_s !== 2'd3) begin
      errors++; $display("FAIL sat_small: got stall=%0d bubble=%0d want 3/3", stall_s, bubble_s);
    end
    checks++;
    if (stall_b !== 16'd5 || bubble_b !== 16'd5) begin
      errors++; $display("FAIL sat_big: got stall=%0d bubble=%0d want 5/5", stall_b, bubble_b);
    end
    idle(); in_valid = 1'b1; instruction = itype(6'h0D, 5'd1, 5'd2, 16'h4321);
    dec_ctrl = 16'h0ACE; step();
    out_ready = 1'b0; step();
    reset = 1'b1; step();
    checks++;
    if (ex_b.out_valid !== 1'b0 || ex_b.out_ctrl !== 16'h0 || ex_b.out_imm !== 32'h0 ||
        stall_b !== 16'h0 || stall_s !== 2'd0) begin
      errors++; $display("FAIL reset_mid_hold: got v=%0b ctrl=%h imm=%h stall=%0d",
                         ex_b.out_valid, ex_b.out_ctrl, ex_b.out_imm, stall_b);
    end
    idle(); step();
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h23};
    logic       exp_ready;
    idle(); reset = 1'b1; step();
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 63) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      hazard_stall = ($urandom_range(0, 4) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      wb_en        = 1'($urandom_range(0, 1));
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      sel_rs       = 2'($urandom_range(0, 3));
      sel_rt       = 2'($urandom_range(0, 3));
      fwd_data     = {$urandom, $urandom, $urandom};
      instruction  = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 16'($urandom)};
      pc_next      = $urandom;
      dec_ctrl     = 16'($urandom);
      #1;
      exp_ready = (!m_valid || out_ready) && !hazard_stall && !reset;
      checks++;
      if (in_ready_b !== exp_ready || in_ready_s !== exp_ready) begin
        errors++; $display("FAIL rnd_in_ready%0d: got %0b/%0b want %0b", c, in_ready_b,
                           in_ready_s, exp_ready);
      end
      step();
      checks++;
      if (ex_b.out_valid !== m_valid || ex_s.out_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid%0d: got %0b/%0b want %0b", c, ex_b.out_valid,
                           ex_s.out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if ({ex_b.out_ctrl, ex_b.out_data_s, ex_b.out_data_t, ex_b.out_imm, ex_b.out_pc_jump,
             ex_b.out_pc_next, ex_b.out_opcode, ex_b.out_funct, ex_b.out_rs, ex_b.out_rt,
             ex_b.out_rd} !==
            {m_ctrl, m_s, m_t, m_imm, m_jump, m_pcn, m_op, m_fn, m_rs, m_rt, m_rd}) begin
          errors++; $display("FAIL rnd_bundle%0d: got s=%h t=%h imm=%h want s=%h t=%h imm=%h",
                             c, ex_b.out_data_s, ex_b.out_data_t, ex_b.out_imm, m_s, m_t, m_imm);
        end
        checks++;
        if (ex_s.out_data_s !== m_s2 || ex_s.out_data_t !== m_t2) begin
          errors++; $display("FAIL rnd_small%0d: got %h/%h want %h/%h", c, ex_s.out_data_s,
                             ex_s.out_data_t, m_s2, m_t2);
        end
      end
      checks++;
      if (stall_b !== 16'(sat(m_stall, 65535)) || bubble_b !== 16'(sat(m_bubble, 65535)) ||
          stall_s !== 2'(sat(m_stall, 3)) || bubble_s !== 2'(sat(m_bubble, 3))) begin
        errors++; $display("FAIL rnd_counters%0d: got %0d/%0d/%0d/%0d want %0d/%0d", c, stall_b,
                           bubble_b, stall_s, bubble_s, m_stall, m_bubble);
      end
    end
    idle(); step();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_write_through();
    test_imm();
    test_forward();
    test_hold_and_bubble();
    test_flush();
    test_saturate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
